// File: rtl/and_nb_pipe_pkg.sv
// Shared helpers for the pipelined N-input AND: tree depth, per-stage widths
// and end-to-end latency, all evaluated at elaboration time.
package and_pipe_pkg;

    localparam int MIN_N_INPUTS = 1;
    localparam int MAX_N_INPUTS = 64;
    localparam int MIN_FANIN    = 2;
    localparam int MAX_FANIN    = 6;

    // Integer ceiling division for positive operands.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Number of FANIN-wide AND stages needed to reduce n bits to one bit.
    // A single input still gets one registered stage.
    function automatic int clog_k(input int n, input int k);
        int w;
        int s;
        w = n;
        s = 0;
        for (int i = 0; i < MAX_N_INPUTS; i++) begin
            if (w > 1) begin
                w = ceil_div(w, k);
                s = s + 1;
            end
        end
        if (s < 1) begin
            s = 1;
        end
        return s;
    endfunction

    // Width of the vector leaving stage j (stage 0 is the masked input).
    function automatic int stage_width(input int j, input int n, input int k);
        int w;
        w = n;
        for (int i = 0; i < MAX_N_INPUTS; i++) begin
            if (i < j) begin
                w = ceil_div(w, k);
            end
        end
        return w;
    endfunction

    // Cycles (with CE=1) from a sample on I to its result on O.
    function automatic int pipe_latency(input int reg_in, input int n, input int k);
        return reg_in + clog_k(n, k);
    endfunction

endpackage

// File: rtl/and_nb_pipe_reduce_stage.sv
// One registered level of the AND tree: groups the incoming vector into
// FANIN-bit chunks from bit 0 upward, ANDs each chunk and registers the
// result together with its valid bit.
module and_reduce_stage
    import and_pipe_pkg::*;
#(
    parameter int  IN_W    = 8,
    parameter int  FANIN   = 4,
    parameter bit  INV_OUT = 1'b0,
    localparam int OUT_W   = ceil_div(IN_W, FANIN)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    input  logic [IN_W-1:0]  data_i,
    input  logic             vld_i,
    output logic [OUT_W-1:0] data_o,
    output logic             vld_o
);

    localparam int PAD_W = OUT_W * FANIN;

    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] data_d;
    logic [OUT_W-1:0] data_q;
    logic             vld_q;

    // Fill the unused top of the last group with ones so it cannot force a 0.
    always_comb begin
        padded             = '1;
        padded[IN_W-1:0]   = data_i;
    end

    // One AND node per group; the final stage may also invert for NAND use.
    always_comb begin
        data_d = '0;
        for (int g = 0; g < OUT_W; g++) begin
            data_d[g] = (&padded[g*FANIN +: FANIN]) ^ INV_OUT;
        end
    end

    // Data and valid advance together only on enabled cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (ce_i) begin
            data_q <= data_d;
            vld_q  <= vld_i;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/and_nb_pipe.sv
// Pipelined N-input AND with a run-time inversion mask per input and an
// optional output inversion. Replaces chains of fixed ANDxBy primitives.
module and_nb_pipe
    import and_pipe_pkg::*;
#(
    parameter int                  N_INPUTS      = 8,
    parameter int                  FANIN         = 4,
    parameter logic [N_INPUTS-1:0] INV_MASK_INIT = '0,
    parameter bit                  OUT_INV       = 1'b0,
    parameter bit                  REG_IN        = 1'b1
) (
    input  logic                C,
    input  logic                CLR_N,
    input  logic                CE,
    input  logic [N_INPUTS-1:0] I,
    input  logic                I_VLD,
    input  logic                MASK_LD,
    input  logic [N_INPUTS-1:0] MASK_D,
    output logic [N_INPUTS-1:0] MASK_Q,
    output logic                O,
    output logic                O_VLD
);

    localparam int S = clog_k(N_INPUTS, FANIN);

    if (N_INPUTS < MIN_N_INPUTS || N_INPUTS > MAX_N_INPUTS) begin : g_bad_n_inputs
        $error("and_nb_pipe: N_INPUTS=%0d outside 1..64", N_INPUTS);
    end
    if (FANIN < MIN_FANIN || FANIN > MAX_FANIN) begin : g_bad_fanin
        $error("and_nb_pipe: FANIN=%0d outside 2..6", FANIN);
    end

    logic [N_INPUTS-1:0] mask_q;
    logic [N_INPUTS-1:0] mask_d;
    logic [N_INPUTS-1:0] masked_d;
    logic [N_INPUTS-1:0] s0_data;
    logic                s0_vld;

    // Mask load ignores CE so software can reprogram while the pipe is stalled.
    always_comb begin
        mask_d = MASK_LD ? MASK_D : mask_q;
    end

    // Mask register; a sample taken on the load edge still sees the old value.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            mask_q <= INV_MASK_INIT;
        end else begin
            mask_q <= mask_d;
        end
    end

    // Per-input inversion, applied before any pipeline register.
    always_comb begin
        masked_d = I ^ mask_q;
    end

    if (REG_IN) begin : g_reg_in
        logic [N_INPUTS-1:0] in_q;
        logic                in_vld_q;

        // Optional input register isolating the masking XOR from the tree.
        always_ff @(posedge C or negedge CLR_N) begin
            if (!CLR_N) begin
                in_q     <= '0;
                in_vld_q <= 1'b0;
            end else if (CE) begin
                in_q     <= masked_d;
                in_vld_q <= I_VLD;
            end
        end

        assign s0_data = in_q;
        assign s0_vld  = in_vld_q;
    end else begin : g_no_reg_in
        assign s0_data = masked_d;
        assign s0_vld  = I_VLD;
    end

    for (genvar j = 1; j <= S; j++) begin : g_stage
        localparam int IW = stage_width(j - 1, N_INPUTS, FANIN);
        localparam int OW = stage_width(j, N_INPUTS, FANIN);

        logic [IW-1:0] din;
        logic          vin;
        logic [OW-1:0] dout;
        logic          vout;

        if (j == 1) begin : g_src
            assign din = s0_data;
            assign vin = s0_vld;
        end else begin : g_src
            assign din = g_stage[j-1].dout;
            assign vin = g_stage[j-1].vout;
        end

        and_reduce_stage #(
            .IN_W    (IW),
            .FANIN   (FANIN),
            .INV_OUT ((j == S) ? OUT_INV : 1'b0)
        ) u_stage (
            .clk_i  (C),
            .rst_ni (CLR_N),
            .ce_i   (CE),
            .data_i (din),
            .vld_i  (vin),
            .data_o (dout),
            .vld_o  (vout)
        );
    end

    assign O      = g_stage[S].dout[0];
    assign O_VLD  = g_stage[S].vout;
    assign MASK_Q = mask_q;

endmodule

// File: tb/tb_and_nb_pipe.sv
// Bench for and_nb_pipe: three configurations driven in lockstep and
// compared every cycle against a sample-history reference model.
module tb_and_nb_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr_n, ce, vld, mask_ld;

    logic [7:0] iA, mdA, mqA;
    logic       oA, ovA;
    logic [4:0] iB, mdB, mqB;
    logic       oB, ovB;
    logic [0:0] iC, mdC, mqC;
    logic       oC, ovC;

    int tests = 0;
    int fails = 0;

    // Reference state: current mask and the last L enabled-cycle samples
    // ({valid, expected result}) since reset.
    logic [7:0] mA;
    logic [4:0] mB;
    logic [0:0] mC;
    logic [1:0] qA[$];
    logic [1:0] qB[$];
    logic [1:0] qC[$];
    logic [1:0] dummy;

    // Defaults, AND8B8-style reset mask, L = 1 + 2 = 3.
    and_nb_pipe #(
        .N_INPUTS(8), .FANIN(4), .INV_MASK_INIT(8'hFF), .OUT_INV(1'b0), .REG_IN(1'b1)
    ) u_a (
        .C(clk), .CLR_N(clr_n), .CE(ce), .I(iA), .I_VLD(vld),
        .MASK_LD(mask_ld), .MASK_D(mdA), .MASK_Q(mqA), .O(oA), .O_VLD(ovA)
    );

    // NAND, padded binary tree 5->3->2->1, no input register, L = 3.
    and_nb_pipe #(
        .N_INPUTS(5), .FANIN(2), .INV_MASK_INIT(5'h00), .OUT_INV(1'b1), .REG_IN(1'b0)
    ) u_b (
        .C(clk), .CLR_N(clr_n), .CE(ce), .I(iB), .I_VLD(vld),
        .MASK_LD(mask_ld), .MASK_D(mdB), .MASK_Q(mqB), .O(oB), .O_VLD(ovB)
    );

    // Minimum configuration, L = 1.
    and_nb_pipe #(
        .N_INPUTS(1), .FANIN(2), .INV_MASK_INIT(1'b0), .OUT_INV(1'b0), .REG_IN(1'b0)
    ) u_c (
        .C(clk), .CLR_N(clr_n), .CE(ce), .I(iC), .I_VLD(vld),
        .MASK_LD(mask_ld), .MASK_D(mdC), .MASK_Q(mqC), .O(oC), .O_VLD(ovC)
    );

    function automatic logic ref_and(input logic [63:0] i, input logic [63:0] m,
                                     input int n, input logic inv);
        logic r;
        r = 1'b1;
        for (int k = 0; k < n; k++) begin
            r = r & (i[k] ^ m[k]);
        end
        return r ^ inv;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [1:0] e;
        e = (qA.size() == 3) ? qA[0] : 2'b00;
        chk("A_vld", 64'(ovA), 64'(e[1]));
        if (e[1]) chk("A_o", 64'(oA), 64'(e[0]));
        chk("A_mask", 64'(mqA), 64'(mA));
        e = (qB.size() == 3) ? qB[0] : 2'b00;
        chk("B_vld", 64'(ovB), 64'(e[1]));
        if (e[1]) chk("B_o", 64'(oB), 64'(e[0]));
        chk("B_mask", 64'(mqB), 64'(mB));
        e = (qC.size() == 1) ? qC[0] : 2'b00;
        chk("C_vld", 64'(ovC), 64'(e[1]));
        if (e[1]) chk("C_o", 64'(oC), 64'(e[0]));
        chk("C_mask", 64'(mqC), 64'(mC));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_A_o"},    64'(oA),  64'd0);
        chk({tag, "_A_vld"},  64'(ovA), 64'd0);
        chk({tag, "_A_mask"}, 64'(mqA), 64'hFF);
        chk({tag, "_B_o"},    64'(oB),  64'd0);
        chk({tag, "_B_vld"},  64'(ovB), 64'd0);
        chk({tag, "_B_mask"}, 64'(mqB), 64'h00);
        chk({tag, "_C_o"},    64'(oC),  64'd0);
        chk({tag, "_C_vld"},  64'(ovC), 64'd0);
        chk({tag, "_C_mask"}, 64'(mqC), 64'h0);
    endtask

    task automatic model_reset();
        qA.delete();
        qB.delete();
        qC.delete();
        mA = 8'hFF;
        mB = 5'h00;
        mC = 1'b0;
    endtask

    // Advance one clock, update the model from the inputs seen on that
    // edge, then compare all outputs shortly after the edge.
    task automatic tick();
        @(posedge clk);
        if (clr_n) begin
            if (ce) begin
                qA.push_back({vld, ref_and(64'(iA), 64'(mA), 8, 1'b0)});
                qB.push_back({vld, ref_and(64'(iB), 64'(mB), 5, 1'b1)});
                qC.push_back({vld, ref_and(64'(iC), 64'(mC), 1, 1'b0)});
                if (qA.size() > 3) dummy = qA.pop_front();
                if (qB.size() > 3) dummy = qB.pop_front();
                if (qC.size() > 1) dummy = qC.pop_front();
            end
            if (mask_ld) begin
                mA = mdA;
                mB = mdB;
                mC = mdC;
            end
        end
        #1;
        check_all();
    endtask

    task automatic rand_inputs();
        iA  = ($urandom_range(0, 1) == 1) ? ~mA : 8'($urandom);
        iB  = ($urandom_range(0, 1) == 1) ? ~mB : 5'($urandom);
        iC  = 1'($urandom);
    endtask

    initial begin
        clr_n = 1'b0; ce = 1'b0; vld = 1'b0; mask_ld = 1'b0;
        iA = '0; iB = '0; iC = '0; mdA = '0; mdB = '0; mdC = '0;
        model_reset();
        #12;
        check_reset("init");
        repeat (2) tick();
        @(negedge clk);
        clr_n = 1'b1;

        // Mask FF: I=00 gives 1, I=01 gives 0; B (mask 0, NAND): 1F->0, 0F->1.
        ce = 1'b1; vld = 1'b1;
        iA = 8'h00; iB = 5'h1F; iC = 1'b1;
        tick();
        iA = 8'h01; iB = 5'h0F; iC = 1'b0;
        tick();
        vld = 1'b0;
        tick();
        chk("A_dir_00", 64'(oA), 64'd1);
        chk("A_dir_00_vld", 64'(ovA), 64'd1);
        chk("B_dir_1F", 64'(oB), 64'd0);
        tick();
        chk("A_dir_01", 64'(oA), 64'd0);
        chk("B_dir_0F", 64'(oB), 64'd1);
        tick();

        // Mask load on the same edge as a sample: that sample uses the old mask.
        mask_ld = 1'b1; mdA = 8'h0F; mdB = 5'h00; mdC = 1'b0;
        iA = 8'hF0; vld = 1'b1;
        tick();
        mask_ld = 1'b0; iA = 8'hF0;
        tick();
        vld = 1'b0;
        chk("A_maskq", 64'(mqA), 64'h0F);
        tick();
        chk("A_oldmask", 64'(oA), 64'd0);
        tick();
        chk("A_newmask", 64'(oA), 64'd1);
        tick();

        // Six samples with CE stalls between them.
        for (int c = 0; c < 18; c++) begin
            ce  = (c % 3 == 0);
            vld = 1'b1;
            rand_inputs();
            tick();
        end
        ce = 1'b1; vld = 1'b0;
        repeat (4) tick();

        // Asynchronous reset with samples in flight.
        vld = 1'b1;
        repeat (3) begin
            rand_inputs();
            tick();
        end
        #2;
        clr_n = 1'b0;
        #1;
        model_reset();
        check_reset("midrst");
        repeat (2) tick();
        @(negedge clk);
        clr_n = 1'b1;
        vld = 1'b0;
        repeat (4) tick();

        // Randomised traffic with stalls and mask reloads.
        repeat (400) begin
            ce      = ($urandom_range(0, 3) != 0);
            vld     = 1'($urandom);
            mask_ld = ($urandom_range(0, 7) == 0);
            mdA     = 8'($urandom);
            mdB     = 5'($urandom);
            mdC     = 1'($urandom);
            rand_inputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
